share_recombiner: RTL and testbench
===================================

SHARE_RECOMBINER -- requirements
Module: share_recombiner

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 8, number of Boolean shares per masked word (legal range 2..16).
REQ-002 SHALL have parameter WIDTH, default 8, bit width of each share and of the recombined word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port s_valid  input  1  share on s_share is presented.
REQ-006 SHALL have port s_ready  output  1  block accepts a share this cycle.
REQ-007 SHALL have port s_share  input  WIDTH  one share; shares arrive in index order 0..NUM_SHARES-1.
REQ-008 SHALL have port s_last  input  1  sender marks final share of the word.
REQ-009 SHALL have port m_valid  output  1  recombined word available.
REQ-010 SHALL have port m_ready  input  1  consumer accepts the word.
REQ-011 SHALL have port m_data  output  WIDTH  XOR of all accepted shares of the word.
REQ-012 SHALL have port m_err  output  1  framing error on this word; qualified by m_valid.
REQ-013 SHALL have port busy  output  1  high while at least one share of a word is held.

Function
REQ-014 SHALL implement a two-state FSM: COLLECT (s_ready=1, m_valid=0) and HOLD (s_ready=0, m_valid=1).
REQ-015 SHALL accept a share only on a cycle with s_valid & s_ready; no other cycle alters the accumulator or share counter.
REQ-016 SHALL load the accumulator with s_share on share index 0 and XOR s_share into it on every later index (XOR, no carries, WIDTH bits).
REQ-017 SHALL keep a share counter of ceil(log2(NUM_SHARES))+1 bits, incremented per accepted share and cleared on entry to COLLECT.
REQ-018 SHALL end a word on the accepted share that has s_last=1 or counter = NUM_SHARES-1, whichever comes first.
REQ-019 SHALL set m_err=1 when the word ends with s_last=1 at counter < NUM_SHARES-1 (short word), or with s_last=0 at counter = NUM_SHARES-1 (missing last flag); else m_err=0.
REQ-020 SHALL register the final XOR into m_data and enter HOLD on the cycle after the ending share is accepted (latency 1 cycle from last share to m_valid).
REQ-021 SHALL hold m_data, m_err and m_valid stable in HOLD until m_valid & m_ready.
REQ-022 SHALL, on the m_valid & m_ready cycle, return to COLLECT next cycle with m_data, m_err and accumulator cleared to 0 (no unmasked value retained).
REQ-023 SHALL NOT accept a share in the same cycle as the output handshake; minimum word period is NUM_SHARES+1 cycles.
REQ-024 SHALL tolerate s_valid gaps of any length between shares without altering the result.
REQ-025 SHALL drive busy=1 when counter != 0 in COLLECT or state is HOLD.
REQ-026 SHALL ignore s_share and s_last when s_valid=0 or s_ready=0.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, force state COLLECT, counter 0, accumulator 0, m_data 0, m_err 0.
REQ-028 SHALL present after reset: s_ready=1, m_valid=0, busy=0; rst has priority over every handshake in the same cycle.
REQ-029 SHALL discard any partially collected or held word on reset mid-operation; the next share accepted is index 0.

Verification
REQ-030 Shares 01,02,04,08,10,20,40,D5 on consecutive cycles, s_last on 8th, m_ready=1 -> m_valid one cycle after 8th share, m_data=AA, m_err=0.
REQ-031 Shares 00 x7 then F0 with s_valid toggling every other cycle -> m_data=F0, m_err=0; s_ready=1 throughout collection.
REQ-032 Word ending with m_ready low 5 cycles -> m_valid, m_data, m_err stable, s_ready=0 for 5 cycles; after handshake m_data=00, s_ready=1.
REQ-033 Shares 11,22,44,88 with s_last on 4th -> m_data=FF, m_err=1; 8 shares without s_last -> m_err=1 with correct XOR.
REQ-034 rst pulse after 4 shares accepted, then 01,02,04,08,10,20,40,D5 -> m_data=AA, m_err=0 (no residue from aborted word).
REQ-035 rst asserted in HOLD with m_ready=1 -> no handshake completes, m_valid=0 and m_data=00 next cycle.

Source files
------------

// File: rtl/share_recombiner_if.sv
// rtl/share_recombiner_if.sv - share input stream and recombined word output bundle
//
// Purpose: groups the share-in and word-out handshakes of share_recombiner.
// Ports (signals):
//   s_valid, s_ready, s_share[WIDTH], s_last : incoming Boolean shares
//   m_valid, m_ready, m_data[WIDTH], m_err   : recombined word and framing flag
// Modports:
//   slave  : the recombiner's view (consumes shares, produces words)
//   master : the environment's view (produces shares, consumes words)
interface share_recombiner_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_share;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_err;

  modport slave (
    input  s_valid, s_share, s_last, m_ready,
    output s_ready, m_valid, m_data, m_err
  );

  modport master (
    output s_valid, s_share, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_err
  );
endinterface

// File: rtl/share_recombiner.sv
// rtl/share_recombiner.sv - XOR recombination of NUM_SHARES Boolean shares into one word
//
// Purpose: accepts shares in index order, XORs them together, and presents the
// unmasked word with a framing-error flag. All internal copies of the unmasked
// value are wiped once the word has been handed off.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : share_recombiner_if.slave (share stream in, word out)
//   busy : high while any share of a word is held
module share_recombiner #(
  parameter int NUM_SHARES = 8,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  share_recombiner_if.slave     bus,
  output logic                  busy
);

  localparam int CW = $clog2(NUM_SHARES) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SHARES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] m_data_q;
  logic             m_err_q;

  logic             accept;
  logic             out_hs;
  logic             word_end;
  logic             word_err;
  logic [WIDTH-1:0] acc_next;

  // Index 0 loads rather than XORs so a stale accumulator can never leak in.
  assign acc_next = (cnt == '0) ? bus.s_share : (acc ^ bus.s_share);
  assign word_end = bus.s_last || (cnt == LAST_IDX);
  assign word_err = (bus.s_last && (cnt < LAST_IDX)) || (!bus.s_last && (cnt == LAST_IDX));

  always_comb begin
    state_next  = state;
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    accept      = 1'b0;
    out_hs      = 1'b0;
    case (state)
      COLLECT: begin
        bus.s_ready = 1'b1;
        accept      = bus.s_valid;
        if (accept && word_end) state_next = HOLD;
      end
      HOLD: begin
        bus.m_valid = 1'b1;
        out_hs      = bus.m_ready;
        if (out_hs) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= COLLECT;
      cnt      <= '0;
      acc      <= '0;
      m_data_q <= '0;
      m_err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
        if (word_end) begin
          m_data_q <= acc_next;
          m_err_q  <= word_err;
        end
      end
      // Handoff wipes every register that held the unmasked value.
      if (out_hs) begin
        acc      <= '0;
        cnt      <= '0;
        m_data_q <= '0;
        m_err_q  <= 1'b0;
      end
    end
  end

  assign bus.m_data = m_data_q;
  assign bus.m_err  = m_err_q;
  assign busy       = (state == HOLD) || (cnt != '0);

endmodule

// File: tb/tb_share_recombiner.sv
// tb/tb_share_recombiner.sv - self-checking bench for share_recombiner
module tb_share_recombiner;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  share_recombiner_if #(.WIDTH(8)) bus ();

  share_recombiner #(.NUM_SHARES(N), .WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] w1[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'hD5};
  logic [7:0] w2[8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF0};
  logic [7:0] w3[4] = '{8'h11, 8'h22, 8'h44, 8'h88};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is the list of shares accepted so far.
  logic [7:0] q[$];
  bit         m_holding = 1'b0;
  logic [7:0] m_word    = '0;
  bit         m_flag    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_holding = 1'b0;
      m_word    = '0;
      m_flag    = 1'b0;
    end else if (m_holding) begin
      if (bus.m_ready) begin
        m_holding = 1'b0;
        m_word    = '0;
        m_flag    = 1'b0;
        q.delete();
      end
    end else if (bus.s_valid) begin
      q.push_back(bus.s_share);
      if (bus.s_last || q.size() == N) begin
        m_holding = 1'b1;
        m_word    = '0;
        foreach (q[i]) m_word = m_word ^ q[i];
        m_flag = (bus.s_last && q.size() < N) || (!bus.s_last && q.size() == N);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model s_ready", 32'(bus.s_ready), 32'(!m_holding));
      chk("model m_valid", 32'(bus.m_valid), 32'(m_holding));
      chk("model busy", 32'(busy), 32'(m_holding || q.size() != 0));
      if (m_holding) begin
        chk("model m_data", 32'(bus.m_data), 32'(m_word));
        chk("model m_err", 32'(bus.m_err), 32'(m_flag));
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last, input int gap);
    bus.s_valid = 1'b1;
    bus.s_share = d;
    bus.s_last  = last;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'($urandom);
    bus.s_share = 8'($urandom);
    repeat (gap) begin
      chk("s_ready in gap", 32'(bus.s_ready), 32'(1));
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_word(input string name, input logic [7:0] d, input logic e);
    int n = 0;
    while (!bus.m_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(0));
    chk({name, " m_data"}, 32'(bus.m_data), 32'(d));
    chk({name, " m_err"}, 32'(bus.m_err), 32'(e));
  endtask

  task automatic handshake(input string name);
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b0;
    chk({name, " post m_valid"}, 32'(bus.m_valid), 32'(0));
    chk({name, " post m_data"}, 32'(bus.m_data), 32'(0));
    chk({name, " post s_ready"}, 32'(bus.s_ready), 32'(1));
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_share = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    cmp_en = 1'b1;
    chk("reset s_ready", 32'(bus.s_ready), 32'(1));
    chk("reset m_valid", 32'(bus.m_valid), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset m_data", 32'(bus.m_data), 32'(0));

    // Back-to-back shares, 8th flagged last.
    for (int i = 0; i < 8; i++) send(w1[i], i == 7, 0);
    expect_word("w1", 8'hAA, 1'b0);
    handshake("w1");

    // Gapped shares.
    for (int i = 0; i < 8; i++) send(w2[i], i == 7, (i == 7) ? 0 : 1);
    expect_word("w2", 8'hF0, 1'b0);
    handshake("w2");

    // Output stalled 5 cycles while sender keeps pushing junk.
    for (int i = 0; i < 8; i++) send(w1[i], i == 7, 0);
    expect_word("stall", 8'hAA, 1'b0);
    bus.s_valid = 1'b1;
    bus.s_share = 8'h5A;
    repeat (5) begin
      chk("stall m_valid", 32'(bus.m_valid), 32'(1));
      chk("stall s_ready", 32'(bus.s_ready), 32'(0));
      chk("stall m_data", 32'(bus.m_data), 32'(8'hAA));
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    handshake("stall");

    // Short word.
    for (int i = 0; i < 4; i++) send(w3[i], i == 3, 0);
    expect_word("short", 8'hFF, 1'b1);
    handshake("short");

    // Missing last flag.
    for (int i = 0; i < 8; i++) send(w1[i], 1'b0, 0);
    expect_word("nolast", 8'hAA, 1'b1);
    handshake("nolast");

    // Reset mid-word.
    for (int i = 0; i < 4; i++) send(w3[i], 1'b0, 0);
    chk("mid busy", 32'(busy), 32'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'(0));
    for (int i = 0; i < 8; i++) send(w1[i], i == 7, 0);
    expect_word("after abort", 8'hAA, 1'b0);
    handshake("after abort");

    // Reset beats the output handshake.
    for (int i = 0; i < 8; i++) send(w2[i], i == 7, 0);
    expect_word("hold rst", 8'hF0, 1'b0);
    rst         = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    bus.m_ready = 1'b0;
    chk("hold rst m_valid", 32'(bus.m_valid), 32'(0));
    chk("hold rst m_data", 32'(bus.m_data), 32'(0));
    chk("hold rst s_ready", 32'(bus.s_ready), 32'(1));

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
